// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for an eight-digit seven-segment display scanned as
// two banks of four digits. Digits k and k+4 light together on separate
// segment buses. Each slot begins with a short all-off gap that hides ghosting
// while the anodes switch. The 32-bit input word is captured once per frame,
// so a frame never mixes old and new digit values.
module seg7_scan_driver #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] hex,
    input  logic [7:0]  blank,
    output logic [6:0]  a_to_g0,
    output logic [6:0]  a_to_g1,
    output logic [7:0]  an,
    output logic        frame_tick
);

    localparam int CNT_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    // Scan position and the per-frame copy of the digit word.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       slot_q, slot_d;
    logic [31:0]      snap_q, snap_d;

    // Registered outputs and their next values.
    logic [7:0] an_q, an_d;
    logic [6:0] seg0_q, seg0_d;
    logic [6:0] seg1_q, seg1_d;
    logic       tick_q, tick_d;

    logic       frame_start;
    logic       in_blank;

    // Hex nibble to {a,b,c,d,e,f,g}, active-high.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h70;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h7B;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h1F;
            4'hC: seg = 7'h4E;
            4'hD: seg = 7'h3D;
            4'hE: seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    assign frame_start = (cnt_q == '0) && (slot_q == 2'd0);
    assign in_blank    = (cnt_q < BLANK_END);

    // Next scan position; the snapshot is taken only at the start of slot 0.
    always_comb begin
        // NOTE: every variable gets a default before any condition, so no
        // path leaves it unassigned and no latch is inferred.
        cnt_d  = cnt_q + 1'b1;
        slot_d = slot_q;
        snap_d = snap_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            slot_d = slot_q + 2'd1;
        end
        if (frame_start) begin
            snap_d = hex;
        end
    end

    // Output values for the current scan position. Decoding from snap_d lets
    // a zero-length blank gap still show the word captured in the same cycle.
    always_comb begin
        an_d   = '0;
        seg0_d = '0;
        seg1_d = '0;
        tick_d = frame_start;
        if (!in_blank) begin
            an_d[{1'b0, slot_q}] = ~blank[{1'b0, slot_q}];
            an_d[{1'b1, slot_q}] = ~blank[{1'b1, slot_q}];
            seg0_d = decode(snap_d[{slot_q, 2'b00} +: 4]);
            seg1_d = decode(snap_d[{1'b1, slot_q, 2'b00} +: 4]);
        end
    end

    // Scan counters and snapshot register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            slot_q <= 2'd0;
            snap_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of block order.
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            snap_q <= snap_d;
        end
    end

    // Output registers, one cycle behind the scan position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_q   <= '0;
            seg0_q <= '0;
            seg1_q <= '0;
            tick_q <= 1'b0;
        end else begin
            an_q   <= an_d;
            seg0_q <= seg0_d;
            seg1_q <= seg1_d;
            tick_q <= tick_d;
        end
    end

    assign an         = an_q;
    assign a_to_g0    = seg0_q;
    assign a_to_g1    = seg1_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with SLOT_CYCLES=8, BLANK_CYCLES=2.
// The stimulus process pushes the expected output word for every clock into a
// queue; a monitor pops one entry per falling edge and compares.
module tb_seg7_scan_driver;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * SLOT;

    // Segment patterns {a..g} for hex digits 0..F.
    localparam logic [6:0] SEG [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic        clk;
    logic        reset;
    logic [31:0] hex;
    logic [7:0]  blank;
    logic [6:0]  a_to_g0;
    logic [6:0]  a_to_g1;
    logic [7:0]  an;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs packed as {an, g0, g1, tick}.
    logic [22:0] exp_q [$];
    string       name_q [$];

    int          k;            // clock edges since reset release
    bit          in_rst;
    logic [31:0] model_snap;
    string       tag;

    seg7_scan_driver #(
        .SLOT_CYCLES (SLOT),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hex       (hex),
        .blank     (blank),
        .a_to_g0   (a_to_g0),
        .a_to_g1   (a_to_g1),
        .an        (an),
        .frame_tick(frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [22:0] got, input logic [22:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got an=%h g0=%h g1=%h tick=%b, expected an=%h g0=%h g1=%h tick=%b",
                     name, got[22:15], got[14:8], got[7:1], got[0],
                     want[22:15], want[14:8], want[7:1], want[0]);
        end
    endtask

    // Output expected after edge number ec of the scan, given the captured
    // word and the blank mask present at that edge.
    function automatic logic [22:0] expect_at(input int ec, input logic [31:0] s, input logic [7:0] b);
        int         cnt  = ec % SLOT;
        int         slot = (ec / SLOT) % 4;
        logic [7:0] e_an = '0;
        logic [6:0] e_g0 = '0;
        logic [6:0] e_g1 = '0;
        logic       e_ft = (ec % FRAME) == 0;
        if (cnt >= BLANK) begin
            e_an[slot]     = ~b[slot];
            e_an[slot + 4] = ~b[slot + 4];
            e_g0 = SEG[s[slot * 4 +: 4]];
            e_g1 = SEG[s[(slot + 4) * 4 +: 4]];
        end
        return {e_an, e_g0, e_g1, e_ft};
    endfunction

    // Advance n clocks, pushing one expected output per edge.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            if (in_rst) begin
                exp_q.push_back('0);
                name_q.push_back($sformatf("%s in_reset", tag));
            end else begin
                if (k % FRAME == 0) model_snap = hex;
                exp_q.push_back(expect_at(k, model_snap, blank));
                name_q.push_back($sformatf("%s k=%0d", tag, k));
                k++;
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset  = 1'b1;
        in_rst = 1'b0;
        k      = 0;
    endtask

    // Monitor: one comparison per falling edge while expectations are queued.
    initial begin
        logic [22:0] want;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                nm   = name_q.pop_front();
                check(nm, {an, a_to_g0, a_to_g1, frame_tick}, want);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        hex        = 32'h8888_8888;
        blank      = 8'h00;
        in_rst     = 1'b1;
        k          = 0;
        model_snap = '0;
        tag        = "reset";

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b0;
        #1 check("reset_async", {an, a_to_g0, a_to_g1, frame_tick}, '0);
        run(3);
        release_reset();

        // Frame of all 8s: tick after first edge, two blank cycles, then 11/7F/7F.
        tag = "all_eights";
        run(FRAME);

        // Full scan order.
        #1 hex = 32'h0011_0110;
        tag = "scan_order";
        run(FRAME);

        // Decode sweep over two frames.
        #1 hex = 32'h7654_3210;
        tag = "decode_lo";
        run(FRAME);
        #1 hex = 32'hFEDC_BA98;
        tag = "decode_hi";
        run(FRAME);

        // Snapshot coherence: a change during slot 2 waits for the next frame.
        #1 hex = 32'h1234_5678;
        tag = "coherence_a";
        run(FRAME + 18);
        #1 hex = 32'h9ABC_DEF0;
        tag = "coherence_b";
        run(FRAME - 18);
        tag = "coherence_c";
        run(FRAME);

        // Blank mask, then a mid-slot change that takes effect next cycle.
        #1 blank = 8'hF0;
        tag = "blank_f0";
        run(20);
        #1 blank = 8'h0F;
        tag = "blank_0f";
        run(FRAME - 20);
        #1 blank = 8'h00;
        hex = 32'hA5A5_5A5A;
        tag = "pre_reset";
        run(21);

        // Scan now sits in slot 2 with cnt=5; reset must clear outputs at once.
        @(negedge clk);
        #1 reset = 1'b0;
        in_rst = 1'b1;
        #1 check("reset_midframe", {an, a_to_g0, a_to_g1, frame_tick}, '0);
        hex = 32'h1357_9BDF;
        tag = "reset2";
        run(3);
        release_reset();
        tag = "after_reset";
        run(FRAME);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the board's eight-digit seven-segment display. It sits directly downstream of the lock FSM and consumes its 32-bit `hex_display` word, one nibble per digit. It scans the digits as two banks of four with independent segment buses, and inserts a blanking gap at each digit switch to suppress ghosting. It also snapshots the input once per frame so that a frame never shows a mix of old and new values.

## Interface
- `SLOT_CYCLES`, default 100000: clock cycles per scan slot (1 ms at 100 MHz). Legal range ≥ 2.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with all anodes off. Legal range 0 ≤ BLANK_CYCLES < SLOT_CYCLES.
- `clk`  in  1  system clock, rising edge. The block uses only this clock.
- `reset`  in  1  asynchronous, active-low reset: 0 resets the block immediately; release is synchronous to `clk`.
- `hex`  in  32  digit nibbles; `hex[4k+3:4k]` is digit k (k = 0..7).
- `blank`  in  8  per-digit suppress; `blank[k]`=1 keeps `an[k]` low.
- `a_to_g0`  out  7  segments for digits 0–3, {a,b,c,d,e,f,g}, active-high.
- `a_to_g1`  out  7  segments for digits 4–7, same encoding.
- `an`  out  8  digit enables, active-high.
- `frame_tick`  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- **State:** `cnt` (0..SLOT_CYCLES-1), `slot` (0..3), `snap[31:0]`, plus the registered outputs.
- **Counting:** `cnt` increments every cycle.
  - When `cnt` reaches SLOT_CYCLES-1, it wraps to 0 and `slot` increments.
  - `slot` wraps from 3 to 0.
- **Snapshot:** on the cycle with `slot`==0 and `cnt`==0, `snap` loads `hex`. `hex` is ignored at all other times.
- **Blanking phase** (`cnt` < BLANK_CYCLES): `an`=0, `a_to_g0`=0, `a_to_g1`=0.
- **Display phase** (`cnt` ≥ BLANK_CYCLES):
  - `an[slot]` = ~`blank[slot]`; `an[slot+4]` = ~`blank[slot+4]`; all other `an` bits are 0.
  - `a_to_g0` = decode(`snap` nibble `slot`).
  - `a_to_g1` = decode(`snap` nibble `slot+4`).
  - The segment buses are driven even for blanked digits. Only `an` suppresses them.
- **Decode** (hex → {a..g}): 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47.
- **`blank` sampling:** `blank` is sampled live every cycle, not snapshotted.
- **Reset asserted (`reset`=0):**
  - `cnt`=0, `slot`=0, `snap`=0.
  - `an`=0, `a_to_g0`=0, `a_to_g1`=0, `frame_tick`=0.
  - These values take effect immediately, including mid-slot or mid-frame, and the scan restarts from slot 0 on release.

## Timing
- All outputs are registered and lag the internal `cnt`/`slot` state by exactly one cycle.
- **First cycle after reset release:** `cnt`=0, `slot`=0, and `snap` loads `hex`. On the following cycle, `frame_tick`=1.
- **Frame period:** 4×SLOT_CYCLES cycles. `frame_tick` pulses exactly once per frame.
- **Per slot:** `an` is low for BLANK_CYCLES output cycles, then holds its pair for SLOT_CYCLES−BLANK_CYCLES cycles.
- **BLANK_CYCLES=0:** `an` switches directly from one pair to the next with no gap.
- **Latency:** a change on `hex` becomes visible at the first display phase of slot 0 of the next frame. Worst case is about 4×SLOT_CYCLES+BLANK_CYCLES+1 cycles.
- **`blank` latency:** a change on `blank` reaches `an` on the next cycle.
- **Simultaneous events:** if `hex` changes on the snapshot cycle itself, the new value is captured.

## Test plan
Benches use SLOT_CYCLES=8, BLANK_CYCLES=2.
- **Reset values:** `reset`=0, `hex`=32'h88888888 → `an`=0, `a_to_g0`=`a_to_g1`=0, `frame_tick`=0. After release, `frame_tick`=1 on the 2nd cycle. `an` stays 0 for 2 more cycles, then becomes 8'h11 with both buses at 7F.
- **Full scan order:** `hex`=32'h00110110, `blank`=0.
  - Slot 0 → `an`=11, g0=7E, g1=30.
  - Slot 1 → `an`=22, g0=30, g1=30.
  - Slot 2 → `an`=44, g0=30, g1=7E.
  - Slot 3 → `an`=88, g0=7E, g1=7E.
  - Each slot has 2 blank cycles followed by 6 lit cycles; the frame length is 32 cycles.
- **Decode sweep:** `hex`=32'h76543210, then 32'hFEDCBA98 → each digit matches the decode table across two frames.
- **Snapshot coherence:** change `hex` during slot 2 → digits keep showing the old value until slot 0 of the next frame. `frame_tick` has exactly one pulse per 32 cycles.
- **Blank mask:** `blank`=8'hF0 → `an` is only 01/02/04/08, and `a_to_g1` still toggles. Changing `blank` mid-slot takes effect on the next cycle.
- **Reset mid-frame:** assert `reset` in slot 2, `cnt`=5 → all outputs are 0 immediately, with no clock edge. After release, the scan restarts at slot 0 with a fresh snapshot and a `frame_tick` pulse.
